// File: rtl/alu_pipe_if.sv
// Request/response bundle between issue logic and the alu_pipe datapath.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1; a
// producer holds valid and payload steady until that edge, ready may depend on valid.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             acc_sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic             busy;
    logic [WIDTH-1:0] acc;
    logic             dbg_mul;    // FSM state: 1 while the multiplier runs

    modport master (
        output in_valid, op, acc_sel, a, b, out_ready,
        input  in_ready, out_valid, result, carry_out, zero, negative, overflow,
               busy, acc, dbg_mul
    );

    modport slave (
        input  in_valid, op, acc_sel, a, b, out_ready,
        output in_ready, out_valid, result, carry_out, zero, negative, overflow,
               busy, acc, dbg_mul
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with flags, carry chaining, an accumulator and a
// WIDTH-cycle shift-add multiplier; one result register shared by all ops.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_ADC = 3'b010,
                           OP_AND = 3'b011, OP_OR  = 3'b100, OP_XOR = 3'b101,
                           OP_MUL = 3'b110, OP_CMP = 3'b111;

    typedef enum logic { S_IDLE, S_MUL } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               out_valid_q, carry_q, zero_q, neg_q, ovf_q, cf_q;
    logic [WIDTH-1:0]   result_q, acc_q;

    logic               in_ready, accept, mul_done;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   flag_src;
    logic               add_ovf, sub_ovf;
    logic               ld_en, ld_keep_acc, ld_c, ld_v;
    logic [WIDTH-1:0]   ld_res, ld_flag_src;

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign op_a     = bus.acc_sel ? acc_q : bus.a;
    assign mul_done = (state_q == S_MUL) && (cnt_q == CW'(WIDTH - 1));

    assign sum     = {1'b0, op_a} + {1'b0, bus.b}
                   + {{WIDTH{1'b0}}, (bus.op == OP_ADC) ? cf_q : 1'b0};
    assign diff    = {1'b0, op_a} + {1'b0, ~bus.b} + (WIDTH + 1)'(1);
    assign add_ovf = (op_a[M] == bus.b[M]) && (sum[M] != op_a[M]);
    assign sub_ovf = (op_a[M] != bus.b[M]) && (diff[M] == bus.b[M]);

    // One partial product per cycle: bit cnt_q of B selects A shifted by cnt_q.
    assign prod_d = prod_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);

    always_comb begin
        ld_en       = 1'b0;
        ld_keep_acc = 1'b0;
        ld_res      = '0;
        ld_c        = 1'b0;
        ld_v        = 1'b0;
        flag_src    = '0;
        if (mul_done) begin
            ld_en    = 1'b1;
            ld_res   = prod_d[WIDTH-1:0];
            ld_c     = |prod_d[2*WIDTH-1:WIDTH];
            flag_src = prod_d[WIDTH-1:0];
        end else if (accept && bus.op != OP_MUL) begin
            ld_en = 1'b1;
            case (bus.op)
                OP_ADD, OP_ADC: begin
                    ld_res = sum[WIDTH-1:0];
                    ld_c   = sum[WIDTH];
                    ld_v   = add_ovf;
                end
                OP_SUB: begin
                    ld_res = diff[WIDTH-1:0];
                    ld_c   = !diff[WIDTH];
                    ld_v   = sub_ovf;
                end
                OP_CMP: begin
                    ld_res      = op_a;
                    ld_c        = !diff[WIDTH];
                    ld_v        = sub_ovf;
                    ld_keep_acc = 1'b1;
                end
                OP_AND:  ld_res = op_a & bus.b;
                OP_OR:   ld_res = op_a | bus.b;
                OP_XOR:  ld_res = op_a ^ bus.b;
                default: ld_res = '0;
            endcase
            flag_src = (bus.op == OP_CMP) ? diff[WIDTH-1:0] : ld_res;
        end
    end
    assign ld_flag_src = flag_src;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            cf_q        <= 1'b0;
            acc_q       <= '0;
        end else begin
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && bus.op == OP_MUL) begin
                        state_q <= S_MUL;
                        a_q     <= op_a;
                        b_q     <= bus.b;
                        cnt_q   <= '0;
                        prod_q  <= '0;
                    end
                end
                S_MUL: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (mul_done) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if (ld_en) begin
                out_valid_q <= 1'b1;
                result_q    <= ld_res;
                carry_q     <= ld_c;
                zero_q      <= (ld_flag_src == '0);
                neg_q       <= ld_flag_src[M];
                ovf_q       <= ld_v;
                cf_q        <= ld_c;
                if (!ld_keep_acc) acc_q <= ld_res;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = (state_q == S_MUL);
    assign bus.acc       = acc_q;
    assign bus.dbg_mul   = (state_q == S_MUL);
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8 with hand-computed expected results.
module tb_alu_pipe;
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_ADC = 3'b010,
                           OP_AND = 3'b011, OP_OR  = 3'b100, OP_XOR = 3'b101,
                           OP_MUL = 3'b110, OP_CMP = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(8)) bus ();

    alu_pipe #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns #1 after the edge on which it was accepted.
    task automatic issue(input logic [2:0] op, input logic sel, input logic [7:0] a, input logic [7:0] b);
        bit done = 0;
        bus.op       = op;
        bus.acc_sel  = sel;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (bus.in_ready) begin
                step();
                done = 1;
                break;
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.a        = 8'hxx;
        bus.b        = 8'hxx;
        if (!done) check_val("accept_timeout", 0, 1);
    endtask

    task automatic expect_res(input string tag, input logic [7:0] res,
                              input logic c, input logic z, input logic n, input logic v);
        check_val({tag, "_valid"}, bus.out_valid, 1'b1);
        check_val({tag, "_result"}, bus.result, res);
        check_val({tag, "_carry"}, bus.carry_out, c);
        check_val({tag, "_zero"}, bus.zero, z);
        check_val({tag, "_neg"}, bus.negative, n);
        check_val({tag, "_ovf"}, bus.overflow, v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = OP_ADD;
        bus.acc_sel   = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_valid", bus.out_valid, 0);
        check_val("rst_result", bus.result, 0);
        check_val("rst_flags", {bus.carry_out, bus.zero, bus.negative, bus.overflow}, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_acc", bus.acc, 0);
        check_val("rst_ready", bus.in_ready, 1);

        issue(OP_ADD, 0, 8'hF0, 8'h20);
        expect_res("add_f0_20", 8'h10, 1, 0, 0, 0);
        check_val("add_acc", bus.acc, 8'h10);

        issue(OP_SUB, 0, 8'h05, 8'h07);
        expect_res("sub_05_07", 8'hFE, 1, 0, 1, 0);
        issue(OP_CMP, 0, 8'h07, 8'h07);
        expect_res("cmp_07_07", 8'h07, 0, 1, 0, 0);
        check_val("cmp_acc_kept", bus.acc, 8'hFE);

        issue(OP_ADD, 0, 8'h7F, 8'h01);
        expect_res("add_7f_01", 8'h80, 0, 0, 1, 1);
        issue(OP_ADD, 0, 8'hFF, 8'h01);
        expect_res("add_ff_01", 8'h00, 1, 1, 0, 0);
        issue(OP_ADC, 1, 8'h55, 8'h00);
        expect_res("adc_acc_cf", 8'h01, 0, 0, 0, 0);

        issue(OP_AND, 0, 8'hF0, 8'h3C);
        expect_res("and", 8'h30, 0, 0, 0, 0);
        issue(OP_OR, 0, 8'hF0, 8'h0F);
        expect_res("or", 8'hFF, 0, 0, 1, 0);
        issue(OP_XOR, 0, 8'hAA, 8'hAA);
        expect_res("xor", 8'h00, 0, 1, 0, 0);

        issue(OP_MUL, 0, 8'h10, 8'h11);
        for (int i = 0; i < 8; i++) begin
            check_val("mul_busy", bus.busy, 1);
            check_val("mul_ready", bus.in_ready, 0);
            check_val("mul_nvalid", bus.out_valid, 0);
            step();
        end
        check_val("mul_busy_end", bus.busy, 0);
        expect_res("mul_10_11", 8'h10, 1, 0, 0, 0);
        check_val("mul_acc", bus.acc, 8'h10);
        step();

        bus.out_ready = 1'b0;
        issue(OP_ADD, 0, 8'h03, 8'h04);
        for (int i = 0; i < 5; i++) begin
            expect_res("stall_hold", 8'h07, 0, 0, 0, 0);
            check_val("stall_ready", bus.in_ready, 0);
            step();
        end
        bus.out_ready = 1'b1;
        issue(OP_ADD, 0, 8'h10, 8'h20);
        expect_res("consume_accept", 8'h30, 0, 0, 0, 0);

        issue(OP_MUL, 0, 8'h03, 8'h05);
        repeat (3) step();
        check_val("abort_pre_busy", bus.busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("abort_busy", bus.busy, 0);
        check_val("abort_valid", bus.out_valid, 0);
        check_val("abort_acc", bus.acc, 0);
        check_val("abort_ready", bus.in_ready, 1);
        check_val("abort_result", bus.result, 0);
        repeat (10) begin
            step();
            check_val("abort_no_stale", bus.out_valid, 0);
        end
        issue(OP_ADC, 0, 8'h01, 8'h01);
        expect_res("adc_after_rst", 8'h02, 0, 0, 0, 0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
